// File: rtl/bcd_calc_pkg.sv
// Shared state codes, segment constants and digit helpers for the BCD add controller.
package bcd_calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_ADD   = 3'd2,
    S_SHOW  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic is_digit(input logic [3:0] v);
    return (v <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_seg7.sv
// BCD digit to active-low seven-segment pattern (bit 0 = a ... bit 6 = g); non-digits blank.
module bcd_seg7
  import bcd_calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_add_ctrl.sv
// Two-digit BCD entry/add/show controller: synchronised load strobe, operand FSM,
// BCD-corrected sum and registered seven-segment/LED outputs.
//
//   state   | meaning
//   S_IDLE  | waiting for operand A, displays blank
//   S_GOT_A | A captured and shown on HEX0, waiting for B
//   S_ADD   | one cycle: form A+B, split into tens/ones
//   S_SHOW  | result shown; a new valid digit starts the next entry as A
//   S_ERR   | invalid digit entered, "E" shown until the next load
module bcd_add_ctrl
  import bcd_calc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] SW,
  input  logic       load,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic [3:0] LEDR
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   ld_pulse_q, ld_pulse_d;
  logic                   run_q, run_d;
  logic                   armed_q, armed_d;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [6:0] hex1_q, hex1_d;
  logic [6:0] hex0_q, hex0_d;
  logic [3:0] ledr_q, ledr_d;

  logic [4:0] sum;
  logic       sum_ge10;
  logic       sw_valid;
  logic [3:0] dec0_in;
  logic [6:0] seg_tens, seg_ones;

  // A key already held when reset releases must not count as a press: pulses stay
  // disarmed until the first synchroniser stage has seen load low after reset.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], load};
    edge_d     = sync_q[SYNC_STAGES-1];
    run_d      = 1'b1;
    armed_d    = armed_q | (run_q & ~sync_q[0]);
    ld_pulse_d = sync_q[SYNC_STAGES-1] & ~edge_q & armed_q;
  end

  assign sw_valid = is_digit(SW);
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign sum_ge10 = (sum >= 5'd10);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE, S_SHOW: begin
        if (ld_pulse_q) begin
          if (sw_valid) begin
            a_d     = SW;
            state_d = S_GOT_A;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_GOT_A: begin
        if (ld_pulse_q) begin
          if (sw_valid) begin
            b_d     = SW;
            state_d = S_ADD;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ADD: begin
        // Low nibble minus ten wraps mod 16 to the correct ones digit for sums 10..18.
        tens_d  = sum_ge10;
        ones_d  = sum_ge10 ? (sum[3:0] - 4'd10) : sum[3:0];
        state_d = S_SHOW;
      end
      S_ERR: begin
        if (ld_pulse_q) begin
          a_d     = '0;
          b_d     = '0;
          tens_d  = 1'b0;
          ones_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dec0_in = (state_q == S_GOT_A) ? a_q : ones_q;

  bcd_seg7 u_seg_tens (
    .bcd ({3'b000, tens_q}),
    .seg (seg_tens)
  );

  bcd_seg7 u_seg_ones (
    .bcd (dec0_in),
    .seg (seg_ones)
  );

  always_comb begin
    hex1_d = SEG_BLANK;
    hex0_d = SEG_BLANK;
    ledr_d = {1'b0, state_q};
    case (state_q)
      S_GOT_A: hex0_d = seg_ones;
      S_ADD: begin
        hex1_d = hex1_q;
        hex0_d = hex0_q;
      end
      S_SHOW: begin
        hex1_d = seg_tens;
        hex0_d = seg_ones;
        ledr_d = {tens_q, state_q};
      end
      S_ERR:   hex0_d = SEG_E;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      ld_pulse_q <= 1'b0;
      run_q      <= 1'b0;
      armed_q    <= 1'b0;
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      tens_q     <= 1'b0;
      ones_q     <= '0;
      hex1_q     <= SEG_BLANK;
      hex0_q     <= SEG_BLANK;
      ledr_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      edge_q     <= edge_d;
      ld_pulse_q <= ld_pulse_d;
      run_q      <= run_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      hex1_q     <= hex1_d;
      hex0_q     <= hex0_d;
      ledr_q     <= ledr_d;
    end
  end

  assign HEX1 = hex1_q;
  assign HEX0 = hex0_q;
  assign LEDR = ledr_q;

endmodule

// File: doc/bcd_add_ctrl.md
# bcd_add_ctrl

Sequencing controller for the two-digit BCD display path. It captures two single-digit BCD operands from the switches on successive debounced `load` strobes, then forms their decimal sum (0–18) with BCD correction. It drives the tens and ones seven-segment displays through every phase of entry and result. It sits between the board switches/keys and HEX1/HEX0, replacing the purely combinational binary-to-BCD display path with a stateful entry/add/show flow.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages in the `load` synchronizer (≥2).
- `CLOCK_50`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `SW`  in  4  operand digit, binary; valid range 0–9.
- `load`  in  1  asynchronous level from an upstream key, already active-high; rising edge = one entry event.
- `HEX1`  out  7  tens display, active-low segments, index 0 = segment a … 6 = g.
- `HEX0`  out  7  ones display, same encoding.
- `LEDR`  out  4  [2:0] = state code, [3] = carry (sum ≥ 10).

## Operation
- `load` passes through a `SYNC_STAGES` synchronizer, then a one-flop edge detector. The resulting `ld_pulse` is one cycle wide per rising edge. Held `load` produces exactly one pulse.
- Digit validity: `SW ≤ 9`. Values 10–15 are invalid.
- States and codes:
  - S_IDLE = 0
  - S_GOT_A = 1
  - S_ADD = 2
  - S_SHOW = 3
  - S_ERR = 4
- Transitions:
  - S_IDLE + ld_pulse: valid → latch A, go to S_GOT_A; invalid → S_ERR.
  - S_GOT_A + ld_pulse: valid → latch B, go to S_ADD; invalid → S_ERR. A is retained but discarded on the next S_IDLE entry.
  - S_ADD: unconditional, one cycle. Computes the 5-bit sum = A + B. Latches tens = (sum ≥ 10), ones = sum − 10·tens. Goes to S_SHOW.
  - S_SHOW + ld_pulse: valid → latch new A, go to S_GOT_A (chained entry); invalid → S_ERR.
  - S_ERR + ld_pulse: go to S_IDLE; SW is ignored.
  - No ld_pulse: hold state.
- An `ld_pulse` arriving while in S_ADD is dropped. It cannot occur from a single key press; the bench checks the drop by forcing the pulse.
- Arithmetic: A and B are 4 bits, the sum is 5 bits (max 18), and the result tens digit is 0 or 1.
- Display per state (registered outputs):
  - S_IDLE: HEX1 blank, HEX0 blank.
  - S_GOT_A: HEX1 blank, HEX0 = A.
  - S_ADD: previous display held.
  - S_SHOW: HEX1 = tens (shows "0" or "1", never blank), HEX0 = ones.
  - S_ERR: HEX1 blank, HEX0 = "E".
- `LEDR[3]` = latched carry in S_SHOW, 0 otherwise.

## Timing
- Reset (synchronous, dominates `ld_pulse`):
  - state S_IDLE; A, B, tens and ones all 0.
  - synchronizer and edge flop cleared.
  - HEX1 = HEX0 = 7'b1111111 (blank); LEDR = 0.
  - All of these hold on the first edge with `reset` = 1.
- `ld_pulse` is high in the cycle following the (SYNC_STAGES+1)-th edge after `load` is first sampled high.
- SW is sampled on the edge where `ld_pulse` = 1; the state changes on that same edge.
- HEX/LEDR reflect the new state one cycle after the state change.
- Result latency: B-capture edge → S_ADD (1 cycle) → S_SHOW; displays show the sum 2 cycles after the B-capture edge.
- Reset asserted mid-sequence (any state, including S_ADD) abandons the operands; there is no partial result.
- SW changing between pulses has no effect; only the pulse-cycle value is used.

## Structure
- Package `bcd_calc_pkg`:
  - state enum and its 3-bit codes.
  - `SEG_BLANK` = 7'b1111111 and `SEG_E` constants.
  - `DIGIT_MAX` = 9.
- Sub-module `bcd_seg7`: combinational 4-bit BCD → active-low 7-segment decoder (0–9 valid, others blank). It is instantiated twice and feeds the output registers.
- The synchronizer, edge detect, FSM, operand/result registers and display mux all live in `bcd_add_ctrl`.

## Test plan
- Reset with `load` held high → HEX1 = HEX0 = 1111111, LEDR = 0. Release reset with `load` still high → no pulse; state remains S_IDLE.
- SW = 7, pulse; SW = 5, pulse → after capture+2 cycles, HEX1 = "1", HEX0 = "2", LEDR = 4'b1011.
- SW = 3, pulse; SW = 4, pulse → HEX1 = "0", HEX0 = "7", LEDR[3] = 0. Then SW = 9, pulse → S_GOT_A, HEX1 blank, HEX0 = "9".
- SW = 9 + SW = 9 → HEX1 = "1", HEX0 = "8" (maximum sum).
- SW = 12, pulse from S_IDLE → HEX0 = "E", LEDR[2:0] = 4. Pulse → S_IDLE, blank. Repeat with the invalid digit entered as B.
- SW = 6, pulse; assert `reset` in the cycle after the B capture (S_ADD) → next cycle S_IDLE, display blank, no sum shown.
